// File: rtl/sm9_accum.sv
// sm9_accum: streaming sign-magnitude packet accumulator with saturation,
// negative-zero normalization and a saturating term counter.
module sm9_accum #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8:0]         in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8:0]         out_data,
    output logic               out_overflow,
    output logic [COUNT_W-1:0] out_count
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t state, state_nxt;
    logic [8:0] acc;
    logic [COUNT_W-1:0] count;
    logic ovf;
    logic take;
    logic same, a_ge, sat, sgn;
    logic [8:0] mag_sum, sum_nrm, in_nrm;
    logic [7:0] mag;

    always_comb begin
        same    = acc[8] == in_data[8];
        mag_sum = {1'b0, acc[7:0]} + {1'b0, in_data[7:0]};
        a_ge    = acc[7:0] >= in_data[7:0];
        sat     = same && mag_sum[8];
        mag     = same ? (sat ? 8'hFF : mag_sum[7:0])
                       : (a_ge ? acc[7:0] - in_data[7:0] : in_data[7:0] - acc[7:0]);
        sgn     = (same || a_ge) ? acc[8] : in_data[8];
        // a zero magnitude always carries a positive sign
        sum_nrm = {sgn & (|mag), mag};
        in_nrm  = {in_data[8] & (|in_data[7:0]), in_data[7:0]};
    end

    always_comb begin
        in_ready  = state != OUT;
        out_valid = state == OUT;
        take      = in_valid && in_ready;
        state_nxt = state;
        if (take)
            state_nxt = in_last ? OUT : ACC;
        else if (out_valid && out_ready)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                acc   <= (state == IDLE) ? in_nrm : sum_nrm;
                count <= (state == IDLE) ? COUNT_W'(1) : count + COUNT_W'(~&count);
                ovf   <= (state != IDLE) && (ovf || sat);
            end else if (out_valid && out_ready) begin
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end
        end
    end

    assign out_data     = acc;
    assign out_overflow = ovf;
    assign out_count    = count;
endmodule

// File: tb/tb_sm9_accum.sv
// tb_sm9_accum: directed and random packets checked against an integer
// reference model of the saturating sign-magnitude accumulator.
module tb_sm9_accum;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [8:0] out_data;
    logic       out_overflow;
    logic [7:0] out_count;

    int n_asrt = 0;
    int n_fail = 0;
    int acc_m = 0;
    int cnt_m = 0;
    bit ovf_m = 0;
    logic [8:0] pkt[$];
    logic [8:0] held;

    sm9_accum #(.COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_overflow(out_overflow), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] exp_data();
        return (acc_m < 0) ? {1'b1, 8'(-acc_m)} : {1'b0, 8'(acc_m)};
    endfunction

    task automatic model_reset();
        acc_m = 0;
        cnt_m = 0;
        ovf_m = 0;
    endtask

    task automatic model_beat(input logic [8:0] d);
        int v;
        v = d[8] ? -int'(d[7:0]) : int'(d[7:0]);
        acc_m += v;
        if (acc_m > 255) begin
            acc_m = 255;
            ovf_m = 1;
        end else if (acc_m < -255) begin
            acc_m = -255;
            ovf_m = 1;
        end
        if (cnt_m < 255) cnt_m++;
    endtask

    function automatic logic [8:0] rnd_op();
        logic [8:0] r;
        r[8] = 1'($urandom_range(1));
        r[7:0] = ($urandom_range(1) == 1) ? 8'($urandom_range(255, 150)) : 8'($urandom_range(255));
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"}, 32'(out_data), 0);
        chk({tag, "_out_ovf"}, 32'(out_overflow), 0);
        chk({tag, "_out_count"}, 32'(out_count), 0);
    endtask

    task automatic beat(input logic [8:0] d, input logic l);
        @(negedge clk);
        chk("pre_in_ready", 32'(in_ready), 1);
        chk("pre_out_valid", 32'(out_valid), 0);
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        @(posedge clk);
        model_beat(d);
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 1);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_out_data"}, 32'(out_data), 32'(exp_data()));
        chk({tag, "_out_ovf"}, 32'(out_overflow), 32'(ovf_m));
        chk({tag, "_out_count"}, 32'(out_count), 32'(cnt_m));
    endtask

    task automatic send_pkt(input string tag, input bit gaps);
        for (int i = 0; i < pkt.size(); i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data = rnd_op();
                in_last = 1'($urandom_range(1));
                @(posedge clk);
            end
            beat(pkt[i], i == pkt.size() - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data = rnd_op();
        in_last = 1'b0;
        check_result(tag);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        model_reset();
        check_idle_outputs({tag, "_drain"});
    endtask

    initial begin
        #1;
        check_idle_outputs("reset_hold");
        #12 rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_rel");

        pkt = '{9'h003, 9'h005, 9'h102};
        send_pkt("basic", 0);
        chk("basic_const", 32'(out_data), 32'h006);
        drain("basic");

        pkt = '{9'h10A, 9'h004};
        send_pkt("neg", 0);
        chk("neg_const", 32'(out_data), 32'h106);
        drain("neg");

        pkt = '{9'h0C8, 9'h064, 9'h132};
        send_pkt("sat", 0);
        chk("sat_const", 32'(out_data), 32'h0CD);
        chk("sat_ovf_const", 32'(out_overflow), 1);
        drain("sat");

        pkt = '{9'h007, 9'h107};
        send_pkt("negzero", 0);
        chk("negzero_const", 32'(out_data), 32'h000);
        drain("negzero");

        pkt = '{9'h100};
        send_pkt("single_negzero", 0);
        chk("single_negzero_const", 32'(out_data), 32'h000);
        chk("single_negzero_cnt", 32'(out_count), 1);
        drain("single_negzero");

        pkt = '{9'h011, 9'h122};
        send_pkt("bp", 0);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = rnd_op();
            in_last = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_stable_data", 32'(out_data), 32'(held));
            check_result("bp_hold");
        end
        in_valid = 1'b0;
        drain("bp");
        pkt = '{9'h001, 9'h001};
        send_pkt("bp_next", 0);
        drain("bp_next");

        beat(9'h050, 1'b0);
        beat(9'h020, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid_pkt");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        check_idle_outputs("rst_mid_rel");
        pkt = '{9'h001};
        send_pkt("after_rst", 0);
        chk("after_rst_const", 32'(out_data), 32'h001);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid_out");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        pkt.delete();
        for (int i = 0; i < 300; i++) pkt.push_back(9'h001 ^ {1'($urandom_range(1)), 8'h00});
        send_pkt("count_sat", 0);
        chk("count_sat_const", 32'(out_count), 32'hFF);
        drain("count_sat");

        for (int p = 0; p < 30; p++) begin
            pkt.delete();
            for (int i = 0; i < int'($urandom_range(6, 1)); i++) pkt.push_back(rnd_op());
            send_pkt("rand", 1);
            drain("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
